// File: rtl/dff_out_monitor.sv
// ============================================================================
// Module      : dff_out_monitor
// Description : Watches the true/complement outputs (Q, nQ) of an upstream
//               flip-flop stage that runs in another clock domain. Both lines
//               are synchronised into the C domain. After a settling period
//               the monitor counts rising and falling edges on Q. With
//               complement checking enabled, it also flags any cycle in
//               which Q equals nQ.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W    : width of rise_cnt / fall_cnt (saturating counters)
//   SETTLE   : consecutive good cycles required in INIT before RUN (1..15)
// Ports
//   C        : in  1      clock, all state updates on the rising edge
//   nR       : in  1      synchronous active-low reset (priority over clr)
//   Q        : in  1      upstream true output, asynchronous to C
//   nQ       : in  1      upstream complement output, asynchronous to C
//   clr      : in  1      synchronous clear of counters, err and FSM
//   rise_cnt : out CNT_W  Q rising edges seen in RUN
//   fall_cnt : out CNT_W  Q falling edges seen in RUN
//   err      : out 1      sticky: Q == nQ observed while in RUN
//   state    : out 2      00 INIT, 01 RUN, 10 ERR
//   valid    : out 1      high only in RUN
// Configuration macro
//   DFF_MON_COMPL_CHK_EN : when defined, nQ is checked against Q during
//                          INIT settling and in RUN. When undefined, nQ
//                          is ignored, err is tied low and ERR is never
//                          entered.
// ============================================================================
`default_nettype none

module dff_out_monitor #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             C,
  input  logic             nR,
  input  logic             Q,
  input  logic             nQ,
  input  logic             clr,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             err,
  output logic [1:0]       state,
  output logic             valid
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]       c_ST_INIT = 2'b00;
  localparam logic [1:0]       c_ST_RUN  = 2'b01;
  localparam logic [1:0]       c_ST_ERR  = 2'b10;
  localparam logic [4:0]       c_SETTLE  = 5'(SETTLE);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic r_qs1;
  logic r_qs2;
  logic r_qp;
  // Two-stage "primed" flag that follows the synchroniser depth. Settling
  // starts only once real samples have reached qs2. Without it the
  // no-check build would leave INIT while qs2 still holds reset zeros.
  logic r_prime1;
  logic r_prime2;

  always_ff @(posedge C) begin
    if (!nR) begin
      r_qs1    <= 1'b0;
      r_qs2    <= 1'b0;
      r_qp     <= 1'b0;
      r_prime1 <= 1'b0;
      r_prime2 <= 1'b0;
    end else begin
      r_qs1    <= Q;
      r_qs2    <= r_qs1;
      // qp tracks qs2 one cycle late, unconditionally. On the INIT->RUN
      // transition it therefore holds the last INIT sample, so the first
      // RUN cycle only sees an edge if Q really moved.
      r_qp     <= r_qs2;
      r_prime1 <= 1'b1;
      r_prime2 <= r_prime1;
    end
  end

  // Complement-check view of the synchronised pair
  logic w_compl_ok;   // qs2 and nqs2 disagree (healthy)
  logic w_compl_bad;  // qs2 and nqs2 agree (fault)

`ifdef DFF_MON_COMPL_CHK_EN
  logic r_nqs1;
  logic r_nqs2;

  always_ff @(posedge C) begin
    if (!nR) begin
      r_nqs1 <= 1'b0;
      r_nqs2 <= 1'b0;
    end else begin
      r_nqs1 <= nQ;
      r_nqs2 <= r_nqs1;
    end
  end

  assign w_compl_ok  = (r_qs2 != r_nqs2);
  assign w_compl_bad = (r_qs2 == r_nqs2);
`else
  // nQ is deliberately ignored in this build
  logic w_unused_nq;
  assign w_unused_nq = nQ;
  assign w_compl_ok  = 1'b1;
  assign w_compl_bad = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_settle;
  logic [3:0] w_settle_nxt;

  always_ff @(posedge C) begin
    if (!nR) begin
      r_state  <= c_ST_INIT;
      r_settle <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    case (r_state)
      c_ST_INIT: begin
        if (r_prime2 && w_compl_ok) begin
          // Leave on the cycle that would bring the count to SETTLE
          if (({1'b0, r_settle} + 5'd1) == c_SETTLE) begin
            w_state_nxt  = c_ST_RUN;
            w_settle_nxt = 4'd0;
          end else begin
            w_settle_nxt = r_settle + 4'd1;
          end
        end else begin
          w_settle_nxt = 4'd0;
        end
      end
      c_ST_RUN: begin
        if (w_compl_bad) begin
          w_state_nxt = c_ST_ERR;
        end
      end
      c_ST_ERR: begin
        w_state_nxt = c_ST_ERR;
      end
      default: begin
        // Encoding 11 is unreachable; recover through INIT
        w_state_nxt  = c_ST_INIT;
        w_settle_nxt = 4'd0;
      end
    endcase
    if (clr) begin
      w_state_nxt  = c_ST_INIT;
      w_settle_nxt = 4'd0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state = r_state;
    valid = (r_state == c_ST_RUN);
  end

  // --------------------------------------------------------------------------
  // Edge counters and sticky error
  // --------------------------------------------------------------------------
  logic             w_in_run;
  logic             w_rise_ev;
  logic             w_fall_ev;
  logic [CNT_W-1:0] r_rise;
  logic [CNT_W-1:0] r_fall;

  assign w_in_run = (r_state == c_ST_RUN);
  // An edge that coincides with a complement fault is not counted
  assign w_rise_ev = w_in_run && !w_compl_bad &&  r_qs2 && !r_qp;
  assign w_fall_ev = w_in_run && !w_compl_bad && !r_qs2 &&  r_qp;

  always_ff @(posedge C) begin
    if (!nR) begin
      r_rise <= '0;
      r_fall <= '0;
    end else if (clr) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      if (w_rise_ev && (r_rise != c_CNT_MAX)) begin
        r_rise <= r_rise + c_CNT_ONE;
      end
      if (w_fall_ev && (r_fall != c_CNT_MAX)) begin
        r_fall <= r_fall + c_CNT_ONE;
      end
    end
  end

  assign rise_cnt = r_rise;
  assign fall_cnt = r_fall;

`ifdef DFF_MON_COMPL_CHK_EN
  logic r_err;

  always_ff @(posedge C) begin
    if (!nR) begin
      r_err <= 1'b0;
    end else if (clr) begin
      r_err <= 1'b0;
    end else if (w_in_run && w_compl_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/dff_out_monitor.md
DFF_OUT_MONITOR -- requirements
Module: dff_out_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the edge counters.
REQ-002 SHALL have parameter SETTLE, default 2, consecutive valid cycles required before counting (range 1..15).
REQ-003 SHALL have port C  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port nR  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port Q  input  1  true output of the upstream dff stage (asynchronous to C).
REQ-006 SHALL have port nQ  input  1  complement output of the upstream dff stage (asynchronous to C).
REQ-007 SHALL have port clr  input  1  synchronous clear of counters, error and state.
REQ-008 SHALL have port rise_cnt  output  CNT_W  count of Q rising edges while in RUN.
REQ-009 SHALL have port fall_cnt  output  CNT_W  count of Q falling edges while in RUN.
REQ-010 SHALL have port err  output  1  sticky flag, Q equal to nQ observed in RUN.
REQ-011 SHALL have port state  output  2  FSM state: 00 INIT, 01 RUN, 10 ERR.
REQ-012 SHALL have port valid  output  1  high only when state is RUN.

Function
REQ-013 SHALL pass Q and nQ each through a two-flop synchronizer (qs1->qs2, nqs1->nqs2) before any use.
REQ-014 SHALL hold a previous-value register qp, loaded from qs2 every cycle.
REQ-015 INIT: settle counter increments when qs2 != nqs2, returns to 0 when qs2 == nqs2; on reaching SETTLE, next state RUN.
REQ-016 On the INIT->RUN transition, qp SHALL equal qs2, so no edge is counted on entry.
REQ-017 RUN: qs2=1, qp=0 increments rise_cnt; qs2=0, qp=1 increments fall_cnt.
REQ-018 Latency: a Q change setting up before clock edge N SHALL appear in rise_cnt/fall_cnt after edge N+2.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 RUN with qs2 == nqs2: next state ERR, err=1; the edge detected in that cycle is not counted.
REQ-021 ERR: counters frozen, err held at 1; exit only via clr or reset.
REQ-022 clr=1 SHALL zero both counters, clear err and settle counter, force INIT, taking priority over any concurrent edge or error.
REQ-023 state encoding 11 is unreachable; if entered, next state SHALL be INIT.

Reset
REQ-024 nR=0 at a rising edge of C SHALL set rise_cnt=0, fall_cnt=0, err=0, state=INIT, valid=0, settle counter=0, synchronizer and qp flops=0.
REQ-025 nR SHALL take priority over clr; reset asserted mid-RUN or mid-ERR discards all counts.
REQ-026 Outputs SHALL be undefined only before the first reset edge.

Configuration
REQ-027 Macro DFF_MON_COMPL_CHK_EN defined: complement checking per REQ-015 and REQ-020 is active.
REQ-028 Macro undefined: INIT leaves after SETTLE cycles regardless of nQ, ERR is never entered, err is tied 0, nQ is unused, and edges on Q are counted unconditionally.

Verification
REQ-029 Reset then Q=0, nQ=1 held: state 00 -> 01 after SETTLE+2 edges, valid=1, counts 0.
REQ-030 RUN, toggle Q/nQ every 13 clocks for 100 clocks: rise_cnt=4, fall_cnt=3, each increment exactly 2 edges after the input change.
REQ-031 CNT_W=3, 10 Q rising edges in RUN: rise_cnt stops at 7.
REQ-032 Macro defined, RUN, force Q=nQ=1 for 3 clocks: state=10, err=1, counts frozen; then clr=1 for 1 clock: state=00, err=0, counts 0.
REQ-033 clr=1 in the same cycle as a detected rising edge: rise_cnt=0 afterward; nR=0 together with clr=1: full reset values.
REQ-034 Macro undefined, Q=nQ=0 held: state reaches 01 after SETTLE+2 edges, err stays 0.
